// File: rtl/master_state_control_if.sv
// rtl/master_state_control_if.sv - game-control signal bundle between master_state_control and its neighbours
interface master_state_control_if;
    logic [3:0] BTN;
    logic       SCORE_TICK;
    logic       COLLISION;
    logic       VS;
    logic [1:0] MASTER_STATE;
    logic [3:0] SCORE;
    logic       GAME_START;

    modport master (
        input  BTN, SCORE_TICK, COLLISION, VS,
        output MASTER_STATE, SCORE, GAME_START
    );

    modport slave (
        output BTN, SCORE_TICK, COLLISION, VS,
        input  MASTER_STATE, SCORE, GAME_START
    );
endinterface

// File: rtl/master_state_control.sv
// rtl/master_state_control.sv - snake game state machine: idle/play/win/lose, score and hold timer
module master_state_control #(
    parameter int WIN_SCORE   = 10,
    parameter int HOLD_FRAMES = 300
) (
    input  logic CLK,
    input  logic RESET,
    master_state_control_if.master bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;
    localparam logic [1:0] ST_LOSE = 2'b11;

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       or_d;
    logic       blk;
    logic [1:0] settle;
    logic       vs_d;
    logic [9:0] frame_cnt;
    logic [1:0] state;
    logic [3:0] score;
    logic       game_start;

    logic       or_sync;
    logic       press;
    logic       vs_fall;
    logic [4:0] score_next;
    logic       win_hit;
    logic [9:0] frame_next;
    logic       hold_hit;

    assign or_sync    = |sync2;
    assign press      = or_sync & ~or_d & ~blk;
    assign vs_fall    = vs_d & ~bus.VS;
    assign score_next = {1'b0, score} + 5'd1;
    assign win_hit    = (score_next == 5'(WIN_SCORE));
    assign frame_next = frame_cnt + 10'd1;
    assign hold_hit   = (frame_next == 10'(HOLD_FRAMES));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync1      <= 4'd0;
            sync2      <= 4'd0;
            or_d       <= 1'b0;
            blk        <= 1'b1;
            settle     <= 2'b00;
            vs_d       <= 1'b0;
            frame_cnt  <= 10'd0;
            state      <= ST_IDLE;
            score      <= 4'd0;
            game_start <= 1'b0;
        end else begin
            sync1      <= bus.BTN;
            sync2      <= sync1;
            or_d       <= or_sync;
            vs_d       <= bus.VS;
            settle     <= {settle[0], 1'b1};
            game_start <= 1'b0;
            // A button held through reset must be released once before it can start a game.
            if (blk && settle[1] && !or_sync)
                blk <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state      <= ST_PLAY;
                        score      <= 4'd0;
                        game_start <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (bus.COLLISION) begin
                        state     <= ST_LOSE;
                        frame_cnt <= 10'd0;
                    end else if (bus.SCORE_TICK) begin
                        if (win_hit) begin
                            score     <= 4'(WIN_SCORE);
                            state     <= ST_WIN;
                            frame_cnt <= 10'd0;
                        end else begin
                            score <= score + 4'd1;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (press) begin
                        state <= ST_IDLE;
                    end else if (vs_fall) begin
                        if (hold_hit)
                            state <= ST_IDLE;
                        else
                            frame_cnt <= frame_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.MASTER_STATE = state;
    assign bus.SCORE        = score;
    assign bus.GAME_START   = game_start;
endmodule

// File: tb/tb_master_state_control.sv
// tb/tb_master_state_control.sv - directed self-checking bench for master_state_control
module tb_master_state_control;
    logic CLK;
    logic RESET;
    int   checks;
    int   passes;

    master_state_control_if bus();

    master_state_control #(.WIN_SCORE(10), .HOLD_FRAMES(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tick_pulse();
        bus.SCORE_TICK = 1'b1;
        cycles(1);
        bus.SCORE_TICK = 1'b0;
    endtask

    task automatic vs_pulse();
        bus.VS = 1'b0;
        cycles(1);
        bus.VS = 1'b1;
        cycles(2);
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.BTN = 4'd0; bus.SCORE_TICK = 1'b0; bus.COLLISION = 1'b0; bus.VS = 1'b1;
        cycles(3);
        checks++; if (bus.MASTER_STATE !== 2'b00) $display("FAIL reset_state: got %b want 00", bus.MASTER_STATE); else passes++;
        checks++; if (bus.SCORE !== 4'd0) $display("FAIL reset_score: got %0d want 0", bus.SCORE); else passes++;
        checks++; if (bus.GAME_START !== 1'b0) $display("FAIL reset_game_start: got %b want 0", bus.GAME_START); else passes++;
        RESET = 1'b1;
        cycles(4);
    endtask

    task automatic test_start();
        logic [1:0] exp_state [1:5];
        logic       exp_gs    [1:5];
        exp_state = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        exp_gs    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.BTN = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            cycles(1);
            checks++; if (bus.MASTER_STATE !== exp_state[i]) $display("FAIL start_state_c%0d: got %b want %b", i, bus.MASTER_STATE, exp_state[i]); else passes++;
            checks++; if (bus.GAME_START !== exp_gs[i]) $display("FAIL start_game_start_c%0d: got %b want %b", i, bus.GAME_START, exp_gs[i]); else passes++;
        end
        checks++; if (bus.SCORE !== 4'd0) $display("FAIL start_score: got %0d want 0", bus.SCORE); else passes++;
        bus.BTN = 4'b0000;
        cycles(3);
    endtask

    task automatic test_play_ignores_press();
        bus.BTN = 4'b1000;
        cycles(4);
        checks++; if (bus.MASTER_STATE !== 2'b01) $display("FAIL play_press_state: got %b want 01", bus.MASTER_STATE); else passes++;
        checks++; if (bus.GAME_START !== 1'b0) $display("FAIL play_press_game_start: got %b want 0", bus.GAME_START); else passes++;
        bus.BTN = 4'b0000;
        cycles(3);
    endtask

    task automatic test_win();
        for (int k = 1; k <= 10; k++) begin
            tick_pulse();
            checks++; if (bus.SCORE !== 4'(k)) $display("FAIL win_score_%0d: got %0d want %0d", k, bus.SCORE, k); else passes++;
            checks++; if (bus.MASTER_STATE !== ((k == 10) ? 2'b10 : 2'b01)) $display("FAIL win_state_%0d: got %b want %b", k, bus.MASTER_STATE, (k == 10) ? 2'b10 : 2'b01); else passes++;
            cycles(3);
        end
    endtask

    task automatic test_win_press();
        vs_pulse();
        vs_pulse();
        tick_pulse();
        checks++; if (bus.MASTER_STATE !== 2'b10) $display("FAIL win_after_2_frames: got %b want 10", bus.MASTER_STATE); else passes++;
        checks++; if (bus.SCORE !== 4'd10) $display("FAIL win_tick_ignored: got %0d want 10", bus.SCORE); else passes++;
        bus.BTN = 4'b0100;
        cycles(2);
        checks++; if (bus.MASTER_STATE !== 2'b10) $display("FAIL win_press_c2: got %b want 10", bus.MASTER_STATE); else passes++;
        cycles(1);
        checks++; if (bus.MASTER_STATE !== 2'b00) $display("FAIL win_press_c3: got %b want 00", bus.MASTER_STATE); else passes++;
        bus.BTN = 4'b0000;
        cycles(3);
        tick_pulse();
        bus.COLLISION = 1'b1;
        cycles(1);
        bus.COLLISION = 1'b0;
        checks++; if (bus.SCORE !== 4'd10) $display("FAIL idle_score_kept: got %0d want 10", bus.SCORE); else passes++;
        checks++; if (bus.MASTER_STATE !== 2'b00) $display("FAIL idle_ignores_tick: got %b want 00", bus.MASTER_STATE); else passes++;
        bus.BTN = 4'b0010;
        cycles(3);
        checks++; if (bus.MASTER_STATE !== 2'b01) $display("FAIL restart_state: got %b want 01", bus.MASTER_STATE); else passes++;
        checks++; if (bus.GAME_START !== 1'b1) $display("FAIL restart_game_start: got %b want 1", bus.GAME_START); else passes++;
        checks++; if (bus.SCORE !== 4'd0) $display("FAIL restart_score: got %0d want 0", bus.SCORE); else passes++;
        bus.BTN = 4'b0000;
        cycles(3);
    endtask

    task automatic test_tick_and_collision();
        for (int k = 0; k < 3; k++) begin
            tick_pulse();
            cycles(1);
        end
        checks++; if (bus.SCORE !== 4'd3) $display("FAIL collide_pre_score: got %0d want 3", bus.SCORE); else passes++;
        bus.SCORE_TICK = 1'b1;
        bus.COLLISION  = 1'b1;
        cycles(1);
        bus.SCORE_TICK = 1'b0;
        bus.COLLISION  = 1'b0;
        checks++; if (bus.MASTER_STATE !== 2'b11) $display("FAIL collide_state: got %b want 11", bus.MASTER_STATE); else passes++;
        checks++; if (bus.SCORE !== 4'd3) $display("FAIL collide_score: got %0d want 3", bus.SCORE); else passes++;
    endtask

    task automatic test_lose_hold();
        tick_pulse();
        checks++; if (bus.SCORE !== 4'd3) $display("FAIL lose_tick_ignored: got %0d want 3", bus.SCORE); else passes++;
        for (int k = 0; k < 3; k++) vs_pulse();
        checks++; if (bus.MASTER_STATE !== 2'b11) $display("FAIL lose_after_3_frames: got %b want 11", bus.MASTER_STATE); else passes++;
        bus.VS = 1'b0;
        cycles(1);
        bus.VS = 1'b1;
        checks++; if (bus.MASTER_STATE !== 2'b00) $display("FAIL lose_after_4_frames: got %b want 00", bus.MASTER_STATE); else passes++;
        checks++; if (bus.SCORE !== 4'd3) $display("FAIL lose_score_kept: got %0d want 3", bus.SCORE); else passes++;
        cycles(2);
    endtask

    task automatic test_reset_mid_play();
        int bad_state;
        int bad_gs;
        bus.BTN = 4'b0001;
        cycles(3);
        checks++; if (bus.MASTER_STATE !== 2'b01) $display("FAIL mid_start_state: got %b want 01", bus.MASTER_STATE); else passes++;
        bus.BTN = 4'b0000;
        cycles(3);
        for (int k = 0; k < 5; k++) begin
            tick_pulse();
            cycles(1);
        end
        checks++; if (bus.SCORE !== 4'd5) $display("FAIL mid_pre_score: got %0d want 5", bus.SCORE); else passes++;
        bus.BTN = 4'b0001;
        cycles(2);
        RESET = 1'b0;
        cycles(1);
        checks++; if (bus.MASTER_STATE !== 2'b00) $display("FAIL mid_reset_state: got %b want 00", bus.MASTER_STATE); else passes++;
        checks++; if (bus.SCORE !== 4'd0) $display("FAIL mid_reset_score: got %0d want 0", bus.SCORE); else passes++;
        RESET = 1'b1;
        bad_state = 0;
        bad_gs    = 0;
        for (int k = 0; k < 8; k++) begin
            cycles(1);
            if (bus.MASTER_STATE !== 2'b00) bad_state++;
            if (bus.GAME_START !== 1'b0) bad_gs++;
        end
        checks++; if (bad_state != 0) $display("FAIL held_btn_state: got %0d cycles out of idle want 0", bad_state); else passes++;
        checks++; if (bad_gs != 0) $display("FAIL held_btn_game_start: got %0d pulses want 0", bad_gs); else passes++;
        bus.BTN = 4'b0000;
        cycles(4);
        bus.BTN = 4'b0001;
        cycles(2);
        checks++; if (bus.MASTER_STATE !== 2'b00) $display("FAIL repress_c2: got %b want 00", bus.MASTER_STATE); else passes++;
        cycles(1);
        checks++; if (bus.MASTER_STATE !== 2'b01) $display("FAIL repress_c3: got %b want 01", bus.MASTER_STATE); else passes++;
        checks++; if (bus.GAME_START !== 1'b1) $display("FAIL repress_game_start: got %b want 1", bus.GAME_START); else passes++;
        bus.BTN = 4'b0000;
        cycles(3);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_start();
        test_play_ignores_press();
        test_win();
        test_win_press();
        test_tick_and_collision();
        test_lose_hold();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/master_state_control.md
MASTER_STATE_CONTROL -- requirements
Module: master_state_control

Interface
REQ-001 Parameter WIN_SCORE, default 10: score at which PLAY ends in WIN; legal range 1..15.
REQ-002 Parameter HOLD_FRAMES, default 300: VS falling edges spent in WIN/LOSE before the automatic return to IDLE (about 5 s at 60 Hz); legal range 1..1023.
REQ-003 CLK  input  1  system clock; all logic is on its rising edge.
REQ-004 RESET  input  1  synchronous, active-low reset.
REQ-005 BTN  input  4  raw push buttons {U,D,L,R}; asynchronous to CLK.
REQ-006 SCORE_TICK  input  1  one-cycle pulse: snake reached target.
REQ-007 COLLISION  input  1  one-cycle pulse: snake hit itself or a wall.
REQ-008 VS  input  1  vertical sync from the VGA interface; CLK domain, active-low pulse.
REQ-009 MASTER_STATE  output  2  registered game state: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE; drives the VGA display selection.
REQ-010 SCORE  output  4  registered current score.
REQ-011 GAME_START  output  1  registered one-cycle pulse that clears snake and target logic.

Function
REQ-012 Each BTN bit passes through a 2-flop synchroniser; a "press" is a rising edge on the OR of the four synchronised bits.
REQ-013 Press latency: MASTER_STATE changes on the 3rd rising CLK edge at which BTN is sampled high (counting that first edge); BTN must stay high at least 3 cycles.
REQ-014 Holding a button produces exactly one press; a further press needs the OR to fall and rise again.
REQ-015 IDLE: a press moves to PLAY; on that same edge SCORE becomes 0 and GAME_START is 1 for exactly one cycle.
REQ-016 IDLE: SCORE_TICK, COLLISION and VS are ignored.
REQ-017 PLAY: presses are ignored; direction control is owned elsewhere.
REQ-018 PLAY: SCORE_TICK with SCORE+1 < WIN_SCORE increments SCORE on the next edge and keeps PLAY.
REQ-019 PLAY: SCORE_TICK with SCORE+1 == WIN_SCORE sets SCORE to WIN_SCORE and moves to WIN on the next edge.
REQ-020 PLAY: COLLISION moves to LOSE on the next edge; SCORE is held.
REQ-021 PLAY: simultaneous SCORE_TICK and COLLISION moves to LOSE; SCORE is not incremented.
REQ-022 On entry to WIN or LOSE the frame counter (10 bits) clears to 0.
REQ-023 WIN/LOSE: each VS high-to-low transition, detected with one delay register, increments the frame counter.
REQ-024 WIN/LOSE: when the increment would reach HOLD_FRAMES, the block moves to IDLE on that edge instead; the counter never exceeds HOLD_FRAMES-1.
REQ-025 WIN/LOSE: a press moves to IDLE on the next edge; a press coinciding with a VS falling edge has the same result.
REQ-026 WIN/LOSE: SCORE holds its final value; SCORE_TICK and COLLISION are ignored.
REQ-027 IDLE: SCORE keeps the last game's score until the next GAME_START.
REQ-028 GAME_START is asserted only on the IDLE->PLAY transition; MASTER_STATE never changes by more than one transition per cycle.

Reset
REQ-029 RESET low at a rising edge forces: MASTER_STATE=00, SCORE=0, GAME_START=0, frame counter=0, synchroniser and edge registers=0.
REQ-030 Reset has priority over every other input in any state, including mid-press and mid-hold; the first press after reset release follows REQ-013.

Verification
REQ-031 Reset release, BTN=0001 held 5 cycles -> MASTER_STATE 00->01 on the 3rd sampling edge; GAME_START high exactly 1 cycle; SCORE=0.
REQ-032 PLAY with WIN_SCORE=10, 10 SCORE_TICK pulses 4 cycles apart -> SCORE counts 1..9, then 10 together with MASTER_STATE=10.
REQ-033 PLAY with SCORE=3, SCORE_TICK and COLLISION in the same cycle -> MASTER_STATE=11, SCORE stays 3.
REQ-034 LOSE with HOLD_FRAMES=4, 4 VS low pulses -> IDLE on the edge after the 4th falling edge; 3 pulses keep LOSE; the SCORE value is retained.
REQ-035 WIN, button press after 2 frames -> IDLE; a second press -> PLAY with SCORE=0 and a GAME_START pulse.
REQ-036 RESET asserted during PLAY with SCORE=5 and BTN held -> next cycle MASTER_STATE=00, SCORE=0; with BTN still held after release there is no start until BTN is released and pressed again.
